input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage between board pins and the timer control path: synchronizes and debounces the start/stop pushbutton, synchronizes the mode and preset switches, and delivers clean single-cycle events to the control FSM and the increment/decrement counter. Every asynchronous input passes through this block before it reaches any other logic in the design, and the block's outputs drive the existing `start_stop`, `mode` and `sw` nets of the top level.

## Interface
Parameters:
- DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range 2..2^CNT_W-1
- CNT_W, 20, debounce/repeat counter width
- REPEAT_DELAY, 50_000_000, hold cycles before the first auto-repeat pulse (used only with the macro)
- REPEAT_PERIOD, 20_000_000, cycles between later auto-repeat pulses (used only with the macro)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start_stop_raw  in  1  raw pushbutton, active-high, bouncing
- mode_raw  in  2  raw mode switches
- sw_raw  in  8  raw preset switches
- start_stop  out  1  one-cycle press pulse
- btn_level  out  1  debounced button level
- mode  out  2  synchronized mode
- sw  out  8  synchronized preset
- mode_changed  out  1  one-cycle pulse on any change of `mode`

## Operation
- Two-flop synchronizer on every raw input: `btn_s`, `mode_s`, `sw_s`.
- Button FSM with debounce counter `cnt`:
  - IDLE: `btn_level`=0. If `btn_s`=1, `cnt` increments; if `btn_s`=0, `cnt` clears. When `cnt`=DB_CYCLES-1 and `btn_s`=1: go to HELD, clear `cnt`, and assert `start_stop` for exactly one cycle.
  - HELD: `btn_level`=1. If `btn_s`=0, `cnt` increments; if `btn_s`=1, `cnt` clears. When `cnt`=DB_CYCLES-1 and `btn_s`=0: go to IDLE, clear `cnt`. No pulse on release.
- Any bounce restarts the count. No pulse is produced for a glitch shorter than DB_CYCLES.
- `cnt` saturates and never wraps.
- `mode` and `sw` are driven directly by `mode_s` and `sw_s`.
- `mode_changed` is registered and asserts for one cycle when `mode_s` differs from its previous-cycle value.
- After reset a `first` flag suppresses `mode_changed` for the first synchronized sample, so a nonzero mode at power-up produces no pulse.
- Simultaneous press acceptance and mode change: both pulses assert in the same cycle. Neither event masks the other.

## Timing
- Reset (asynchronous assert, synchronous release by the flops): all outputs 0, synchronizers 0, FSM in IDLE, `cnt`=0, `first`=1.
- Press latency: with `start_stop_raw` high and stable from clock edge k, `start_stop` is high during the cycle after edge k+DB_CYCLES+1, for exactly one cycle.
- `btn_level` rises together with `start_stop` and falls DB_CYCLES+2 edges after the raw input falls.
- `mode` and `sw` latency: 2 cycles. `mode_changed` latency: 3 cycles after the raw change.
- If reset asserts while the button is held, the FSM returns to IDLE. After release of reset, a still-held button produces one fresh pulse after the full debounce time.

## Configuration
- `INPUT_COND_AUTOREPEAT_EN` defined:
  - While in HELD, a repeat counter emits an additional one-cycle `start_stop` pulse REPEAT_DELAY cycles after acceptance.
  - It then emits one every REPEAT_PERIOD cycles until release debounce begins.
  - The repeat counter clears whenever the FSM leaves HELD.
- Macro undefined: exactly one pulse per accepted press. The REPEAT_* parameters are ignored and no repeat counter is synthesized.

## Test plan
Run with DB_CYCLES=4 unless noted.
- Clean press: raw high from edge 10 and held → `start_stop` high exactly in cycle 16, `btn_level`=1 from cycle 16, no further pulse (macro undefined).
- Bounce: raw toggles 1,0,1,0 on consecutive cycles, then stays high → exactly one pulse, 6 cycles after the last rising toggle; a 3-cycle glitch alone → no pulse.
- Release: hold for 20 cycles, then drop → `btn_level` falls 6 cycles later, `start_stop` stays 0; a second press then yields a second pulse.
- Mode: reset released with `mode_raw`=2'b10 → `mode`=2 after 2 cycles and no `mode_changed`; change to 2'b01 → `mode_changed` one cycle, 3 cycles later; change coincident with press acceptance → both pulses in the same cycle.
- Reset mid-hold: assert reset while in HELD → all outputs 0 immediately; release reset with the button still held → new pulse 6 cycles after release.
- Auto-repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold for 30 cycles → pulses at acceptance, acceptance+10, +15, +20, +25; none after raw falls.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes board inputs and debounces the start/stop button into single-cycle events.
// Optional auto-repeat of held-button pulses is enabled by defining INPUT_COND_AUTOREPEAT_EN.
module input_conditioner #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int CNT_W         = 20,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop_raw,
    input  logic [1:0] mode_raw,
    input  logic [7:0] sw_raw,
    output logic       start_stop,
    output logic       btn_level,
    output logic [1:0] mode,
    output logic [7:0] sw,
    output logic       mode_changed
);

    typedef enum logic {S_IDLE, S_HELD} state_t;

    if (DB_CYCLES < 2 || 64'(DB_CYCLES) > (64'd1 << CNT_W) - 64'd1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("input_conditioner: illegal parameter combination");
    end

    state_t           r_state, w_state_nxt;
    logic             r_btn_m, r_btn_s;
    logic [1:0]       r_mode_m, r_mode_s, r_mode_prev;
    logic [7:0]       r_sw_m, r_sw_s;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_vld;
    logic             r_first, r_start_stop, r_mode_changed;
    logic             w_disagree, w_done, w_press, w_pulse;

    // Two-flop synchronizers for every asynchronous pin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_m  <= 1'b0;
            r_btn_s  <= 1'b0;
            r_mode_m <= '0;
            r_mode_s <= '0;
            r_sw_m   <= '0;
            r_sw_s   <= '0;
        end else begin
            r_btn_m  <= start_stop_raw;
            r_btn_s  <= r_btn_m;
            r_mode_m <= mode_raw;
            r_mode_s <= r_mode_m;
            r_sw_m   <= sw_raw;
            r_sw_s   <= r_sw_m;
        end
    end

    // Debounce next-state: count samples disagreeing with the accepted level, flip after DB_CYCLES of them
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_disagree  = (r_state == S_IDLE) ? r_btn_s : ~r_btn_s;
        w_done      = w_disagree && r_cnt == CNT_W'(DB_CYCLES - 1);
        if (!w_disagree) begin
            w_cnt_nxt = '0;
        end else if (w_done) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == S_IDLE) ? S_HELD : S_IDLE;
        end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        w_press = w_done && r_state == S_IDLE;
    end

    // Button state, debounce counter and registered press pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_start_stop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_start_stop <= w_pulse;
        end
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt;
    logic             r_rpt_after;
    logic             w_rpt_run, w_rpt_fire;

    // Repeat counter only runs while the button is held and still reads pressed
    assign w_rpt_run  = r_state == S_HELD && r_btn_s;
    assign w_rpt_fire = w_rpt_run && r_rpt == RPT_W'((r_rpt_after ? REPEAT_PERIOD : REPEAT_DELAY) - 1);
    assign w_pulse    = w_press | w_rpt_fire;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; leaving HELD rearms the long delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rpt       <= '0;
            r_rpt_after <= 1'b0;
        end else if (!w_rpt_run) begin
            r_rpt <= '0;
            if (r_state != S_HELD) r_rpt_after <= 1'b0;
        end else if (w_rpt_fire) begin
            r_rpt       <= '0;
            r_rpt_after <= 1'b1;
        end else begin
            r_rpt <= r_rpt + 1'b1;
        end
    end
`else
    assign w_pulse = w_press;
`endif

    // Mode change detector; the first flag holds off until the synchronizer carries a real sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld          <= '0;
            r_first        <= 1'b1;
            r_mode_prev    <= '0;
            r_mode_changed <= 1'b0;
        end else begin
            r_vld          <= {r_vld[0], 1'b1};
            r_first        <= r_first & ~r_vld[1];
            r_mode_prev    <= r_mode_s;
            r_mode_changed <= ~r_first && r_mode_s != r_mode_prev;
        end
    end

    assign start_stop   = r_start_stop;
    assign btn_level    = r_state == S_HELD;
    assign mode         = r_mode_s;
    assign sw           = r_sw_s;
    assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner against a behavioural model.
module tb_input_conditioner;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int HOLD20_PULSES = 2;
`else
    localparam int HOLD20_PULSES = 1;
`endif

    logic       clk = 0;
    logic       reset = 0;
    logic       start_stop_raw = 0;
    logic [1:0] mode_raw = 0;
    logic [7:0] sw_raw = 0;
    logic       start_stop, btn_level, mode_changed;
    logic [1:0] mode;
    logic [7:0] sw;
    int         n_vec = 0;
    int         n_err = 0;

    input_conditioner #(.DB_CYCLES(DB), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .start_stop_raw(start_stop_raw), .mode_raw(mode_raw), .sw_raw(sw_raw),
        .start_stop(start_stop), .btn_level(btn_level), .mode(mode), .sw(sw), .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    // Reference: inputs appear two edges late; the level flips after DB consecutive disagreeing samples
    logic [10:0] m_d1 = 0, m_d2 = 0;
    logic        e_lvl = 0, e_ss = 0, e_mc = 0, m_b = 0, m_nrep = 0;
    logic [1:0]  m_m = 0, m_prev = 0;
    int          m_run = 0, m_age = 0, m_rpt = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d1 = 0; m_d2 = 0; e_lvl = 0; e_ss = 0; e_mc = 0; m_prev = 0;
            m_run = 0; m_age = 0; m_rpt = 0; m_nrep = 0;
        end else begin
            m_b = m_d2[10];
            m_m = m_d2[9:8];
            e_ss = 0;
            m_run = (m_b != e_lvl) ? m_run + 1 : 0;
            if (m_run == DB) begin
                e_lvl = ~e_lvl; m_run = 0; e_ss = e_lvl; m_rpt = 0; m_nrep = 0;
            end
`ifdef INPUT_COND_AUTOREPEAT_EN
            else if (e_lvl && m_b) begin
                m_rpt++;
                if (m_rpt == (m_nrep ? RP : RD)) begin e_ss = 1; m_rpt = 0; m_nrep = 1; end
            end else m_rpt = 0;
`endif
            m_age = (m_age < 10) ? m_age + 1 : m_age;
            e_mc = (m_age >= 4) && (m_m != m_prev);
            m_prev = m_m;
            m_d2 = m_d1;
            m_d1 = {start_stop_raw, mode_raw, sw_raw};
        end
    end

    wire [12:0] w_obs = {start_stop, btn_level, mode, sw, mode_changed};
    wire [12:0] w_exp = {e_ss, e_lvl, m_d2[9:8], m_d2[7:0], e_mc};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start_stop_raw = 1; mode_raw = 2'b11; sw_raw = 8'hA5;
        repeat (3) tick();
        n_vec++;
        if (w_obs !== 13'd0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", w_obs); end
        start_stop_raw = 0; mode_raw = 2'b10;
        @(negedge clk) reset = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL post_reset model: got %h expected %h", w_obs, w_exp); end
            n_vec++;
            if (mode !== ((i >= 2) ? 2'b10 : 2'b00) || mode_changed !== 1'b0) begin
                n_err++; $display("FAIL power_up_mode edge %0d: got mode %b mc %b", i, mode, mode_changed);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0, at = 0;
        start_stop_raw = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL clean_press model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) begin pulses++; at = i; end
        end
        n_vec++;
        if (pulses != 1 || at != DB + 2 || btn_level !== 1'b1) begin
            n_err++; $display("FAIL clean_press: got %0d pulses at edge %0d level %b, expected 1 at %0d level 1", pulses, at, btn_level, DB + 2);
        end
        start_stop_raw = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL clean_release model: got %h expected %h", w_obs, w_exp); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat = 4'b0101;
        int pulses = 0, at = 0;
        for (int i = 1; i <= 18; i++) begin
            start_stop_raw = (i <= 4) ? pat[i-1] : 1'b1;
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL bounce model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) begin pulses++; at = i; end
        end
        n_vec++;
        if (pulses != 1 || at != 5 + DB + 1) begin
            n_err++; $display("FAIL bounce: got %0d pulses at edge %0d, expected 1 at %0d", pulses, at, 5 + DB + 1);
        end
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            start_stop_raw = (i >= 9 && i <= 11);
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL glitch model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) pulses++;
        end
        n_vec++;
        if (pulses != 0 || btn_level !== 1'b0) begin
            n_err++; $display("FAIL glitch: got %0d pulses level %b, expected 0 pulses level 0", pulses, btn_level);
        end
    endtask

    task automatic test_release();
        int pulses = 0, fall = 0;
        start_stop_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL hold model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) pulses++;
        end
        n_vec++;
        if (pulses != HOLD20_PULSES) begin n_err++; $display("FAIL hold_pulses: got %0d expected %0d", pulses, HOLD20_PULSES); end
        start_stop_raw = 0;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL release model: got %h expected %h", w_obs, w_exp); end
            if (start_stop && i > 2) pulses++;
            if (!btn_level && fall == 0) fall = i;
        end
        n_vec++;
        if (fall != DB + 2 || pulses != 0) begin
            n_err++; $display("FAIL release: level fell at edge %0d with %0d pulses, expected %0d with 0", fall, pulses, DB + 2);
        end
        start_stop_raw = 1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL second_press model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) pulses++;
        end
        n_vec++;
        if (pulses != 1) begin n_err++; $display("FAIL second_press: got %0d pulses expected 1", pulses); end
        start_stop_raw = 0;
        repeat (9) tick();
    endtask

    task automatic test_mode();
        int at = 0;
        logic both = 0;
        mode_raw = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL mode model: got %h expected %h", w_obs, w_exp); end
            if (mode_changed) at = (at == 0) ? i : -1;
        end
        n_vec++;
        if (at != 3 || mode !== 2'b01) begin n_err++; $display("FAIL mode_change: pulse at %0d mode %b, expected 3 and 01", at, mode); end
        start_stop_raw = 1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) mode_raw = 2'b11;
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL coincident model: got %h expected %h", w_obs, w_exp); end
            if (i == DB + 2) both = start_stop & mode_changed;
        end
        n_vec++;
        if (both !== 1'b1) begin n_err++; $display("FAIL coincident: got %b expected both pulses together", both); end
        start_stop_raw = 0;
        repeat (9) tick();
    endtask

    task automatic test_reset_mid_hold();
        int at = 0;
        start_stop_raw = 1;
        repeat (8) tick();
        #2 reset = 0;
        #1;
        n_vec++;
        if (w_obs !== 13'd0) begin n_err++; $display("FAIL async_reset: got %h expected 0", w_obs); end
        repeat (2) tick();
        @(negedge clk) reset = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL rehold model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) at = (at == 0) ? i : -1;
        end
        n_vec++;
        if (at != DB + 2) begin n_err++; $display("FAIL rehold_pulse: got edge %0d expected %0d", at, DB + 2); end
        start_stop_raw = 0;
        repeat (9) tick();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin start_stop_raw = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 2 * DB + 4); end
            hold--;
            if ($urandom_range(0, 7) == 0) mode_raw = 2'($urandom);
            sw_raw = 8'($urandom);
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL random cycle %0d: got %h expected %h", i, w_obs, w_exp); end
        end
        start_stop_raw = 0;
        repeat (9) tick();
    endtask

`ifdef INPUT_COND_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int q[$];
        start_stop_raw = 1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 31) start_stop_raw = 0;
            tick();
            n_vec++;
            if (w_obs !== w_exp) begin n_err++; $display("FAIL autorepeat model: got %h expected %h", w_obs, w_exp); end
            if (start_stop) q.push_back(i);
        end
        n_vec++;
        if (q.size() != 5 || q[0] != DB + 2 || q[1] != q[0] + RD || q[2] != q[1] + RP || q[3] != q[2] + RP || q[4] != q[3] + RP) begin
            n_err++; $display("FAIL autorepeat: got %0d pulses %p", q.size(), q);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_mode();
        test_reset_mid_hold();
        test_random();
`ifdef INPUT_COND_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
